// File: rtl/dist_pkg.sv
// Shared sizes, FSM encoding and helpers for the distribution histogram block.
// The DIST_HIST_CLAMP_EN option is handled in dist_bin_index.
package dist_pkg;

  localparam int NUM_BINS   = 16;
  localparam int BIN_W      = 16;
  localparam int DIST_W     = NUM_BINS * BIN_W;
  localparam int REG_ADDR_W = 5;
  localparam int IDX_W      = 4;
  localparam int SMP_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2
  } dist_state_t;

  typedef logic [BIN_W-1:0] bin_t;

  function automatic bin_t sat_inc(input bin_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dist_hist_accum_if.sv
// Control, sample stream and register-file write bundle of the histogram unit.
// master = client driving samples, slave = dist_hist_accum.
interface dist_hist_accum_if;
  import dist_pkg::*;

  logic                  start;
  logic [REG_ADDR_W-1:0] dstAddr;
  logic [SMP_W-1:0]      base;
  logic                  sampleValid;
  logic [SMP_W-1:0]      sample;
  logic                  sampleReady;
  logic                  finish;
  logic                  busy;
  logic                  DRegWrite;
  logic [REG_ADDR_W-1:0] wrAddr;
  logic [DIST_W-1:0]     wrData;

  modport master (
    output start,
    output dstAddr,
    output base,
    output sampleValid,
    output sample,
    output finish,
    input  sampleReady,
    input  busy,
    input  DRegWrite,
    input  wrAddr,
    input  wrData
  );

  modport slave (
    input  start,
    input  dstAddr,
    input  base,
    input  sampleValid,
    input  sample,
    input  finish,
    output sampleReady,
    output busy,
    output DRegWrite,
    output wrAddr,
    output wrData
  );

endinterface

// File: rtl/dist_bin_index.sv
// Maps a sample onto a bin index relative to the latched base.
// DIST_HIST_CLAMP_EN folds out-of-range samples into the edge bins.
module dist_bin_index
  import dist_pkg::*;
#(
  parameter int BIN_SHIFT = 4
) (
  input  logic [SMP_W-1:0] sample,
  input  logic [SMP_W-1:0] base,
  output logic [IDX_W-1:0] index,
  output logic             inRange
);

  logic signed [SMP_W:0] diff;
  logic signed [SMP_W:0] idx_full;
  logic                  neg;
  logic                  over;

  assign diff     = $signed({1'b0, sample}) - $signed({1'b0, base});
  assign idx_full = diff >>> BIN_SHIFT;
  assign neg      = diff[SMP_W];
  assign over     = !neg && (idx_full[SMP_W:IDX_W] != '0);

`ifdef DIST_HIST_CLAMP_EN
  always_comb begin
    unique case (1'b1)
      neg:     index = '0;
      over:    index = IDX_W'(NUM_BINS - 1);
      default: index = idx_full[IDX_W-1:0];
    endcase
  end

  assign inRange = 1'b1;
`else
  assign index   = idx_full[IDX_W-1:0];
  assign inRange = !(neg || over);
`endif

endmodule

// File: rtl/dist_hist_accum.sv
// Accumulates a 16-bin histogram and writes it to one distribution register.
// Build option: DIST_HIST_CLAMP_EN (clamp instead of discard out-of-range).
module dist_hist_accum
  import dist_pkg::*;
#(
  parameter int BIN_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  dist_hist_accum_if.slave   bus
);

  dist_state_t           state_q;
  logic [REG_ADDR_W-1:0] dst_q;
  logic [SMP_W-1:0]      base_q;
  bin_t                  bins_q [NUM_BINS];
  bin_t                  bins_d [NUM_BINS];
  logic [DIST_W-1:0]     pack_d;
  logic                  sampleReady_q;
  logic                  busy_q;
  logic                  DRegWrite_q;
  logic [REG_ADDR_W-1:0] wrAddr_q;
  logic [DIST_W-1:0]     wrData_q;

  logic [IDX_W-1:0]      idx;
  logic                  in_rng;
  logic                  accept;

  dist_bin_index #(
    .BIN_SHIFT (BIN_SHIFT)
  ) u_idx (
    .sample  (bus.sample),
    .base    (base_q),
    .index   (idx),
    .inRange (in_rng)
  );

  assign accept = bus.sampleValid && (state_q == ST_ACCUM);

  always_comb begin
    bins_d = bins_q;
    if (accept && in_rng) begin
      bins_d[idx] = sat_inc(bins_q[idx]);
    end
  end

  // Packed from bins_d so a sample taken with finish lands in the write.
  always_comb begin
    pack_d = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      pack_d[i*BIN_W +: BIN_W] = bins_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dst_q         <= '0;
      base_q        <= '0;
      bins_q        <= '{default: '0};
      sampleReady_q <= 1'b0;
      busy_q        <= 1'b0;
      DRegWrite_q   <= 1'b0;
      wrAddr_q      <= '0;
      wrData_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          DRegWrite_q <= 1'b0;
          if (bus.start) begin
            state_q       <= ST_ACCUM;
            dst_q         <= bus.dstAddr;
            base_q        <= bus.base;
            bins_q        <= '{default: '0};
            sampleReady_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_ACCUM: begin
          bins_q <= bins_d;
          if (bus.finish) begin
            state_q       <= ST_WRITE;
            sampleReady_q <= 1'b0;
            DRegWrite_q   <= 1'b1;
            wrAddr_q      <= dst_q;
            wrData_q      <= pack_d;
          end
        end
        ST_WRITE: begin
          state_q     <= ST_IDLE;
          DRegWrite_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q       <= ST_IDLE;
          sampleReady_q <= 1'b0;
          busy_q        <= 1'b0;
          DRegWrite_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sampleReady = sampleReady_q;
  assign bus.busy        = busy_q;
  assign bus.DRegWrite   = DRegWrite_q;
  assign bus.wrAddr      = wrAddr_q;
  assign bus.wrData      = wrData_q;

endmodule

// File: tb/tb_dist_hist_accum.sv
// Directed bench for dist_hist_accum with a write scoreboard.
// Define DIST_HIST_CLAMP_EN for both DUT and bench to check the clamp build.
module tb_dist_hist_accum;

  localparam int SH = 4;

  typedef struct {
    logic [4:0]   a;
    logic [255:0] d;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dist_hist_accum_if bus();

  dist_hist_accum #(
    .BIN_SHIFT (SH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wr    = 0;
  int   n_exp   = 0;
  wr_t  exp_q[$];
  logic prev_wr = 1'b0;

  int          m_bins[16];
  logic [31:0] m_base;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] req);
    n_tests++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  // Write monitor: every rising DRegWrite pops one scoreboard entry.
  always @(negedge clk) begin
    if (bus.DRegWrite === 1'b1) begin
      chk("wr_pulse_width", {255'b0, prev_wr}, 256'd0);
      if (!prev_wr) begin
        wr_t w;
        n_wr++;
        chk("wr_expected", {255'b0, exp_q.size() != 0}, 256'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("wr_addr", {251'b0, bus.wrAddr}, {251'b0, w.a});
          chk("wr_data", bus.wrData, w.d);
        end
      end
    end
    prev_wr = (bus.DRegWrite === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.dstAddr = a;
    bus.base    = b;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic send(input logic [31:0] s);
    bus.sampleValid = 1'b1;
    bus.sample      = s;
    tick();
    bus.sampleValid = 1'b0;
  endtask

  task automatic do_finish(input logic [4:0] a, input logic [255:0] d,
                           input bit with_s, input logic [31:0] s);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
    n_exp++;
    bus.finish      = 1'b1;
    bus.sampleValid = with_s;
    bus.sample      = s;
    tick();
    bus.finish      = 1'b0;
    bus.sampleValid = 1'b0;
    chk("wr_latency", {255'b0, bus.DRegWrite}, 256'd1);
    chk("busy_write", {255'b0, bus.busy}, 256'd1);
    tick();
    chk("wr_one_cycle", {255'b0, bus.DRegWrite}, 256'd0);
    chk("wraddr_hold", {251'b0, bus.wrAddr}, {251'b0, a});
    chk("wrdata_hold", bus.wrData, d);
    chk("busy_idle", {255'b0, bus.busy}, 256'd0);
  endtask

  function automatic void m_add(input logic [31:0] s);
    longint d;
    longint k;
    d = longint'(s) - longint'(m_base);
    k = (d < 0) ? -1 : (d >> SH);
    if (k < 0) begin
`ifdef DIST_HIST_CLAMP_EN
      k = 0;
`else
      return;
`endif
    end
    if (k > 15) begin
`ifdef DIST_HIST_CLAMP_EN
      k = 15;
`else
      return;
`endif
    end
    if (m_bins[k] < 65535) m_bins[k]++;
  endfunction

  function automatic logic [255:0] m_pack();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = 16'(m_bins[i]);
    return r;
  endfunction

  initial begin
    logic [255:0] e;
    logic [31:0]  s;

    bus.start       = 1'b0;
    bus.dstAddr     = '0;
    bus.base        = '0;
    bus.sampleValid = 1'b0;
    bus.sample      = '0;
    bus.finish      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_busy", {255'b0, bus.busy}, 256'd0);
    chk("rst_ready", {255'b0, bus.sampleReady}, 256'd0);
    chk("rst_wr", {255'b0, bus.DRegWrite}, 256'd0);
    chk("rst_wraddr", {251'b0, bus.wrAddr}, 256'd0);
    chk("rst_wrdata", bus.wrData, 256'd0);

    // finish and samples while idle must do nothing
    bus.finish      = 1'b1;
    bus.sampleValid = 1'b1;
    bus.sample      = 32'd5;
    tick();
    bus.finish      = 1'b0;
    bus.sampleValid = 1'b0;
    tick();
    chk("idle_finish_busy", {255'b0, bus.busy}, 256'd0);

    // basic histogram
    do_start(5'd7, 32'd100);
    chk("accum_busy", {255'b0, bus.busy}, 256'd1);
    chk("accum_ready", {255'b0, bus.sampleReady}, 256'd1);
    send(32'd100);
    send(32'd115);
    send(32'd116);
    send(32'd355);
    e = '0;
    e[0 +: 16]      = 16'd2;
    e[16 +: 16]     = 16'd1;
    e[16*15 +: 16]  = 16'd1;
    do_finish(5'd7, e, 1'b0, 32'd0);

    // out-of-range samples, back-to-back start
    do_start(5'd12, 32'd100);
    send(32'd99);
    send(32'd400);
    e = '0;
`ifdef DIST_HIST_CLAMP_EN
    e[0 +: 16]     = 16'd1;
    e[16*15 +: 16] = 16'd1;
`endif
    do_finish(5'd12, e, 1'b0, 32'd0);

    // sample together with finish
    do_start(5'd5, 32'd100);
    e = '0;
    e[32 +: 16] = 16'd1;
    do_finish(5'd5, e, 1'b1, 32'd132);

    // reset mid-histogram: no write, next histogram starts clean
    do_start(5'd3, 32'd100);
    send(32'd100);
    send(32'd120);
    send(32'd140);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {255'b0, bus.busy}, 256'd0);
    chk("abort_ready", {255'b0, bus.sampleReady}, 256'd0);
    chk("abort_wr", {255'b0, bus.DRegWrite}, 256'd0);
    chk("abort_wraddr", {251'b0, bus.wrAddr}, 256'd0);
    chk("abort_wrdata", bus.wrData, 256'd0);
    tick();
    do_start(5'd6, 32'd100);
    send(32'd116);
    e = '0;
    e[16 +: 16] = 16'd1;
    do_finish(5'd6, e, 1'b0, 32'd0);

    // start during ACCUM is ignored (address and base kept)
    do_start(5'd2, 32'd0);
    do_start(5'd9, 32'd1000);
    chk("restart_busy", {255'b0, bus.busy}, 256'd1);
    send(32'd40);
    e = '0;
    e[32 +: 16] = 16'd1;
    do_finish(5'd2, e, 1'b0, 32'd0);

    // mixed stream with gaps against the reference model
    m_base = 32'd1000;
    for (int i = 0; i < 16; i++) m_bins[i] = 0;
    do_start(5'd20, m_base);
    for (int i = 0; i < 80; i++) begin
      s = 32'($urandom_range(900, 1300));
      bus.sample      = s;
      bus.sampleValid = ($urandom_range(0, 3) != 0);
      if (bus.sampleValid) m_add(s);
      tick();
    end
    bus.sampleValid = 1'b0;
    do_finish(5'd20, m_pack(), 1'b0, 32'd0);

    // saturation
    do_start(5'd1, 32'd5000);
    bus.sampleValid = 1'b1;
    bus.sample      = 32'd5000;
    repeat (65540) tick();
    bus.sampleValid = 1'b0;
    e = '0;
    e[0 +: 16] = 16'hFFFF;
    do_finish(5'd1, e, 1'b0, 32'd0);

    repeat (3) tick();
    chk("queue_empty", 256'(exp_q.size()), 256'd0);
    chk("write_count", 256'(n_wr), 256'(n_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dist_hist_accum.md
DIST_HIST_ACCUM -- requirements
Module: dist_hist_accum

Interface
REQ-001 SHALL have parameter BIN_SHIFT, default 4, log2 of bin width in sample units.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin new histogram; honoured only in IDLE.
REQ-005 SHALL have port dstAddr  input  5  destination distribution register, sampled with start.
REQ-006 SHALL have port base  input  32  unsigned lower edge of bin 0, sampled with start.
REQ-007 SHALL have port sampleValid  input  1  sample present this cycle.
REQ-008 SHALL have port sample  input  32  unsigned sample value.
REQ-009 SHALL have port sampleReady  output  1  high only in ACCUM.
REQ-010 SHALL have port finish  input  1  close histogram; honoured only in ACCUM.
REQ-011 SHALL have port busy  output  1  high in ACCUM and WRITE.
REQ-012 SHALL have ports DRegWrite (output, 1), wrAddr (output, 5), wrData (output, 256), matching the distribution register file write port.

Function
REQ-013 SHALL implement FSM IDLE -> ACCUM (start) -> WRITE (finish) -> IDLE (unconditional, one cycle).
REQ-014 SHALL on accepted start latch dstAddr and base and clear all 16 bins in the same edge.
REQ-015 SHALL accept a sample on any cycle with sampleValid & sampleReady.
REQ-016 SHALL compute diff = sample - base as 33-bit signed; index = diff >> BIN_SHIFT.
REQ-017 SHALL pack bin i in wrData[16*i+15:16*i], 16 bins x 16-bit counts.
REQ-018 SHALL increment the selected bin by 1, saturating at 16'hFFFF (no wrap).
REQ-019 SHALL count a sample accepted in the same cycle as finish, then enter WRITE.
REQ-020 SHALL in WRITE drive DRegWrite=1, wrAddr=latched dstAddr, wrData=final bins, for exactly one cycle; write latency = 1 cycle after finish edge.
REQ-021 SHALL hold DRegWrite=0 in all other states; wrAddr/wrData hold last values.
REQ-022 SHALL ignore start outside IDLE, finish outside ACCUM, and sampleValid outside ACCUM.
REQ-023 SHALL allow start in the cycle following WRITE (back-to-back histograms, no bubble beyond IDLE cycle).

Reset
REQ-024 SHALL on reset enter IDLE and clear bins, wrData=0, wrAddr=0, DRegWrite=0, busy=0, sampleReady=0.
REQ-025 SHALL abort any in-progress histogram on reset with no register-file write issued, including reset asserted during WRITE (DRegWrite=0 next cycle).

Configuration
REQ-026 SHALL, with DIST_HIST_CLAMP_EN defined, map diff<0 to bin 0 and index>15 to bin 15.
REQ-027 SHALL, without DIST_HIST_CLAMP_EN, discard out-of-range samples (no bin changes, sample still consumed).

Structure
REQ-028 SHALL take NUM_BINS=16, BIN_W=16, DIST_W=256, REG_ADDR_W=5 and FSM state encoding from shared package dist_pkg.
REQ-029 SHALL place bin-index computation and range/clamp logic in combinational sub-module dist_bin_index (outputs 4-bit index, inRange).

Verification
REQ-030 SHALL cover: start dstAddr=7 base=100; samples 100,115,116,355; finish -> one write wrAddr=7, bin0=2, bin1=1, bin15=1, others 0.
REQ-031 SHALL cover: sample=99 and sample=400 with base=100 -> bin0/bin15 each +1 with DIST_HIST_CLAMP_EN, all bins 0 without.
REQ-032 SHALL cover: 65540 samples of value base -> bin0=16'hFFFF, no wrap.
REQ-033 SHALL cover: sampleValid with finish same cycle, sample=132, base=100 -> bin2=1 in written wrData; DRegWrite high exactly one cycle.
REQ-034 SHALL cover: reset asserted in ACCUM after 3 samples -> no DRegWrite, next histogram starts all-zero.
REQ-035 SHALL cover: start asserted during ACCUM with dstAddr=9 -> ignored; write goes to original dstAddr.
